sap_controller_sequencer: RTL and testbench
===========================================

Name: sap_controller_sequencer

Overview:
- Controller-sequencer for the SAP-1 datapath, and the initiator for every block on the W-bus, including the program counter.
- Contains a one-hot 6-state ring counter (T1..T6) that decodes the instruction-register opcode into the active-high control word each cycle.
- The control word drives the program counter's inc and pc_out_en inputs, plus the MAR, RAM, IR, accumulator, ALU, B and output-register controls.
- Stops the machine on HLT.

Parameters:
- OP_W, 4, opcode width (upper nibble of the IR).
- OP_LDA, 4'h0, load accumulator from memory.
- OP_ADD, 4'h1, A <= A + B(mem).
- OP_SUB, 4'h2, A <= A - B(mem).
- OP_OUT, 4'hE, copy A to the output register.
- OP_HLT, 4'hF, halt.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- clr  in  1  asynchronous active-high reset.
- opcode  in  OP_W  IR upper nibble; valid from T4 onward.
- inc  out  1  PC increment enable (Cp).
- pc_out_en  out  1  PC drives W-bus (Ep).
- mar_ld  out  1  MAR loads from bus (Lm).
- ram_out_en  out  1  RAM drives bus (CE).
- ir_ld  out  1  IR loads from bus (Li).
- ir_out_en  out  1  IR lower nibble drives bus (Ei).
- a_ld  out  1  accumulator load (La).
- a_out_en  out  1  accumulator drives bus (Ea).
- alu_sub  out  1  ALU subtract select (Su).
- alu_out_en  out  1  ALU drives bus (Eu).
- b_ld  out  1  B register load (Lb).
- out_ld  out  1  output register load (Lo).
- hlt  out  1  machine halted; the clock-gating consumer stops the datapath.
- tstate  out  6  one-hot ring state, bit0 = T1, for debug and bench.

Behaviour:
- Reset
  - Asynchronous reset (clr high) forces the ring to T1 (tstate = 6'b000001).
  - While clr is high, every control output and hlt is 0, regardless of state.
  - The first rising edge after clr falls does not advance the ring: T1 is presented for the full first cycle with clr low.
- Ring counter
  - Advances T1->T2->...->T6->T1, one state per rising edge.
  - Exactly one bit of tstate is set at all times.
  - An illegal state (all zero or multi-hot) recovers to T1 on the next edge.
- Control outputs
  - Combinational decode of (tstate, opcode), gated by !clr.
  - Every output not listed below is 0.
- Fetch (all opcodes)
  - T1: pc_out_en, mar_ld.
  - T2: inc.
  - T3: ram_out_en, ir_ld.
- Execute
  - LDA: T4 ir_out_en, mar_ld; T5 ram_out_en, a_ld; T6 none.
  - ADD: T4 ir_out_en, mar_ld; T5 ram_out_en, b_ld; T6 alu_out_en, a_ld.
  - SUB: same as ADD, with alu_sub also asserted in T5 and T6.
  - OUT: T4 a_out_en, out_ld; T5 and T6 none.
  - HLT, on entering T4:
    - hlt asserts and the ring freezes in T4; all other outputs stay 0.
    - Only clr leaves this state.
    - hlt stays high as long as the ring is frozen, even if the opcode input changes.
  - Undefined opcode: T4..T6 issue no controls (NOP); the ring continues.
- Bus rules
  - At most one *_out_en asserted in any cycle.
  - A bench assertion must check this every cycle.
- Timing
  - One instruction takes 6 cycles, except HLT.
  - inc is asserted exactly once per instruction, so PC wrap 4'hF->4'h0 is the PC's concern.
  - The sequencer has no address awareness.
- Reset mid-instruction: any state, including halt, returns to T1 immediately with all outputs 0; the frozen halt state is cleared.
- Opcode changes during T1..T3 have no effect on outputs.

Decomposition:
- Shared package sap_pkg holds:
  - the opcode constants OP_LDA..OP_HLT;
  - the T-state one-hot localparams T1..T6;
  - the control-word bit index constants, so the top level and bench share one ordering.
- One natural sub-module, sap_ring_counter:
  - ports clk, clr and hold (hold = halt freeze);
  - output is the 6-bit one-hot state.
- The decode stays in sap_controller_sequencer.

Test Plan:
1. Reset and fetch: clr high for 10 ns, then release, opcode = 4'h0.
   - During clr: all outputs 0.
   - Cycle 1: pc_out_en = mar_ld = 1.
   - Cycle 2: inc = 1.
   - Cycle 3: ram_out_en = ir_ld = 1.
2. LDA (opcode 4'h0) over 12 cycles: T4 ir_out_en + mar_ld; T5 ram_out_en + a_ld; T6 all 0; repeats.
   - inc pulses twice, on cycles 2 and 8.
3. SUB (opcode 4'h2): T5 = {ram_out_en, b_ld, alu_sub}; T6 = {alu_out_en, a_ld, alu_sub}.
   - alu_sub = 0 in T1..T4.
4. HLT (opcode 4'hF):
   - hlt rises in T4 and tstate holds 6'b001000 for 20 cycles with all controls 0.
   - Changing opcode to 4'h0 changes nothing.
   - clr pulse -> T1 with hlt = 0.
5. Reset mid-op: clr asserted asynchronously mid-cycle in T5 of ADD.
   - Outputs go 0 without waiting for a clk edge; tstate = 6'b000001.
   - After release, normal fetch.
6. Undefined opcode 4'h7 and OUT (4'hE) back-to-back:
   - 4'h7: T4..T6 all 0.
   - OUT: T4 a_out_en + out_ld.
   - The single-bus-driver assertion is never violated.

Source files
------------

// File: rtl/sap_pkg.sv
// rtl/sap_pkg.sv - shared opcodes, T-state encodings and control-word bit ordering for the SAP-1 sequencer
package sap_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_LDA = 4'h0;
    localparam logic [OP_W-1:0] OP_ADD = 4'h1;
    localparam logic [OP_W-1:0] OP_SUB = 4'h2;
    localparam logic [OP_W-1:0] OP_OUT = 4'hE;
    localparam logic [OP_W-1:0] OP_HLT = 4'hF;

    localparam int TS_W = 6;

    localparam logic [TS_W-1:0] T1 = 6'b000001;
    localparam logic [TS_W-1:0] T2 = 6'b000010;
    localparam logic [TS_W-1:0] T3 = 6'b000100;
    localparam logic [TS_W-1:0] T4 = 6'b001000;
    localparam logic [TS_W-1:0] T5 = 6'b010000;
    localparam logic [TS_W-1:0] T6 = 6'b100000;

    // Control-word bit positions; hlt sits just above the word at index CW_W.
    localparam int CW_INC     = 0;
    localparam int CW_PC_OUT  = 1;
    localparam int CW_MAR_LD  = 2;
    localparam int CW_RAM_OUT = 3;
    localparam int CW_IR_LD   = 4;
    localparam int CW_IR_OUT  = 5;
    localparam int CW_A_LD    = 6;
    localparam int CW_A_OUT   = 7;
    localparam int CW_ALU_SUB = 8;
    localparam int CW_ALU_OUT = 9;
    localparam int CW_B_LD    = 10;
    localparam int CW_OUT_LD  = 11;
    localparam int CW_W       = 12;

    typedef logic [CW_W-1:0] cw_t;

    function automatic logic is_onehot(input logic [TS_W-1:0] s);
        return (s != '0) && ((s & (s - 6'd1)) == '0);
    endfunction

endpackage

// File: rtl/sap_ring_counter.sv
// rtl/sap_ring_counter.sv - one-hot T1..T6 ring with halt freeze and illegal-state recovery
module sap_ring_counter
    import sap_pkg::*;
(
    input  logic            clk,
    input  logic            clr,
    input  logic            hold,
    output logic [TS_W-1:0] state
);

    logic            armed;
    logic [TS_W-1:0] state_nxt;

    // armed holds T1 through the first edge after clr so T1 gets a full clean cycle.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= T1;
            armed <= 1'b0;
        end else begin
            state <= state_nxt;
            armed <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!is_onehot(state)) begin
            state_nxt = T1;
        end else if (armed && !hold) begin
            state_nxt = {state[TS_W-2:0], state[TS_W-1]};
        end
    end

endmodule

// File: rtl/sap_controller_sequencer.sv
// rtl/sap_controller_sequencer.sv - SAP-1 controller-sequencer: ring counter plus opcode decode to control word
module sap_controller_sequencer
    import sap_pkg::*;
(
    input  logic            clk,
    input  logic            clr,
    input  logic [OP_W-1:0] opcode,
    output logic            inc,
    output logic            pc_out_en,
    output logic            mar_ld,
    output logic            ram_out_en,
    output logic            ir_ld,
    output logic            ir_out_en,
    output logic            a_ld,
    output logic            a_out_en,
    output logic            alu_sub,
    output logic            alu_out_en,
    output logic            b_ld,
    output logic            out_ld,
    output logic            hlt,
    output logic [TS_W-1:0] tstate
);

    logic halted;
    logic halt;
    cw_t  cw;

    // halted latches the halt so later opcode changes cannot release the freeze.
    assign halt = halted || ((tstate == T4) && (opcode == OP_HLT));

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            halted <= 1'b0;
        end else if (halt) begin
            halted <= 1'b1;
        end
    end

    sap_ring_counter u_ring (
        .clk   (clk),
        .clr   (clr),
        .hold  (halt),
        .state (tstate)
    );

    always_comb begin
        cw = '0;
        case (tstate)
            T1: begin
                cw[CW_PC_OUT] = 1'b1;
                cw[CW_MAR_LD] = 1'b1;
            end
            T2: cw[CW_INC] = 1'b1;
            T3: begin
                cw[CW_RAM_OUT] = 1'b1;
                cw[CW_IR_LD]   = 1'b1;
            end
            T4: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        cw[CW_IR_OUT] = 1'b1;
                        cw[CW_MAR_LD] = 1'b1;
                    end
                    OP_OUT: begin
                        cw[CW_A_OUT]  = 1'b1;
                        cw[CW_OUT_LD] = 1'b1;
                    end
                    default: ;
                endcase
            end
            T5: begin
                case (opcode)
                    OP_LDA: begin
                        cw[CW_RAM_OUT] = 1'b1;
                        cw[CW_A_LD]    = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        cw[CW_RAM_OUT] = 1'b1;
                        cw[CW_B_LD]    = 1'b1;
                        cw[CW_ALU_SUB] = (opcode == OP_SUB);
                    end
                    default: ;
                endcase
            end
            T6: begin
                if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
                    cw[CW_ALU_OUT] = 1'b1;
                    cw[CW_A_LD]    = 1'b1;
                    cw[CW_ALU_SUB] = (opcode == OP_SUB);
                end
            end
            default: ;
        endcase
        if (clr || halt) begin
            cw = '0;
        end
    end

    assign inc        = cw[CW_INC];
    assign pc_out_en  = cw[CW_PC_OUT];
    assign mar_ld     = cw[CW_MAR_LD];
    assign ram_out_en = cw[CW_RAM_OUT];
    assign ir_ld      = cw[CW_IR_LD];
    assign ir_out_en  = cw[CW_IR_OUT];
    assign a_ld       = cw[CW_A_LD];
    assign a_out_en   = cw[CW_A_OUT];
    assign alu_sub    = cw[CW_ALU_SUB];
    assign alu_out_en = cw[CW_ALU_OUT];
    assign b_ld       = cw[CW_B_LD];
    assign out_ld     = cw[CW_OUT_LD];
    assign hlt        = halt && !clr;

endmodule

// File: tb/tb_sap_controller_sequencer.sv
// tb/tb_sap_controller_sequencer.sv - directed plus randomized checks of the SAP-1 sequencer against a T-state model
module tb_sap_controller_sequencer;
    import sap_pkg::*;

    logic            clk = 1'b0;
    logic            clr;
    logic [OP_W-1:0] opcode;
    logic inc, pc_out_en, mar_ld, ram_out_en, ir_ld, ir_out_en;
    logic a_ld, a_out_en, alu_sub, alu_out_en, b_ld, out_ld, hlt;
    logic [TS_W-1:0] tstate;
    logic [CW_W:0]   dw;

    int n_cmp = 0;
    int n_fail = 0;
    int t;
    bit halted_m;
    bit fresh;
    int inc_seen;

    sap_controller_sequencer dut (
        .clk        (clk),
        .clr        (clr),
        .opcode     (opcode),
        .inc        (inc),
        .pc_out_en  (pc_out_en),
        .mar_ld     (mar_ld),
        .ram_out_en (ram_out_en),
        .ir_ld      (ir_ld),
        .ir_out_en  (ir_out_en),
        .a_ld       (a_ld),
        .a_out_en   (a_out_en),
        .alu_sub    (alu_sub),
        .alu_out_en (alu_out_en),
        .b_ld       (b_ld),
        .out_ld     (out_ld),
        .hlt        (hlt),
        .tstate     (tstate)
    );

    always #5 clk = ~clk;

    always_comb begin
        dw = '0;
        dw[CW_INC]     = inc;
        dw[CW_PC_OUT]  = pc_out_en;
        dw[CW_MAR_LD]  = mar_ld;
        dw[CW_RAM_OUT] = ram_out_en;
        dw[CW_IR_LD]   = ir_ld;
        dw[CW_IR_OUT]  = ir_out_en;
        dw[CW_A_LD]    = a_ld;
        dw[CW_A_OUT]   = a_out_en;
        dw[CW_ALU_SUB] = alu_sub;
        dw[CW_ALU_OUT] = alu_out_en;
        dw[CW_B_LD]    = b_ld;
        dw[CW_OUT_LD]  = out_ld;
        dw[CW_W]       = hlt;
    end

    always @(negedge clk) begin
        if (!clr) begin
            n_cmp++;
            assert ($countones({pc_out_en, ram_out_en, ir_out_en, a_out_en, alu_out_en}) <= 1)
            else begin
                n_fail++;
                $error("FAIL bus_single_driver observed=%0d drivers expected<=1",
                       $countones({pc_out_en, ram_out_en, ir_out_en, a_out_en, alu_out_en}));
            end
        end
    end

    function automatic bit model_hlt();
        return halted_m || ((t == 4) && (opcode == OP_HLT));
    endfunction

    // Expected control set per instruction step, taken straight from the micro-op table.
    function automatic logic [CW_W:0] model_word(input int ts, input logic [OP_W-1:0] op, input bit hl);
        logic [CW_W:0] w;
        bit mem_op;
        bit alu_op;
        w = '0;
        mem_op = (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB);
        alu_op = (op == OP_ADD) || (op == OP_SUB);
        if (hl) begin
            w[CW_W] = 1'b1;
            return w;
        end
        if (ts == 1) begin w[CW_PC_OUT] = 1'b1; w[CW_MAR_LD] = 1'b1; end
        if (ts == 2) w[CW_INC] = 1'b1;
        if (ts == 3) begin w[CW_RAM_OUT] = 1'b1; w[CW_IR_LD] = 1'b1; end
        if (ts == 4 && mem_op) begin w[CW_IR_OUT] = 1'b1; w[CW_MAR_LD] = 1'b1; end
        if (ts == 4 && op == OP_OUT) begin w[CW_A_OUT] = 1'b1; w[CW_OUT_LD] = 1'b1; end
        if (ts == 5 && op == OP_LDA) begin w[CW_RAM_OUT] = 1'b1; w[CW_A_LD] = 1'b1; end
        if (ts == 5 && alu_op) begin w[CW_RAM_OUT] = 1'b1; w[CW_B_LD] = 1'b1; end
        if (ts == 6 && alu_op) begin w[CW_ALU_OUT] = 1'b1; w[CW_A_LD] = 1'b1; end
        if ((ts == 5 || ts == 6) && op == OP_SUB) w[CW_ALU_SUB] = 1'b1;
        return w;
    endfunction

    task automatic chk(input string tag, input logic [CW_W:0] obs, input logic [CW_W:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        t = 1;
        fresh = 1'b1;
        halted_m = 1'b0;
    endtask

    task automatic advance();
        if (fresh) fresh = 1'b0;
        else if (model_hlt()) halted_m = 1'b1;
        else t = (t == 6) ? 1 : t + 1;
    endtask

    task automatic cycle(input string tag);
        logic [TS_W-1:0] ets;
        @(posedge clk);
        advance();
        @(negedge clk);
        ets = 6'd1 << (t - 1);
        chk(tag, dw, model_word(t, opcode, model_hlt()));
        chk({tag, "_ts"}, 13'(tstate), 13'(ets));
        if (inc) inc_seen++;
    endtask

    // Call right after a negedge check: clr is pulsed well clear of the next rising edge.
    task automatic async_clr(input string tag);
        #2 clr = 1'b1;
        #1;
        chk({tag, "_outs"}, dw, '0);
        chk({tag, "_ts"}, 13'(tstate), 13'(T1));
        #1 clr = 1'b0;
        model_reset();
    endtask

    // Opcode is garbage until the edge into T4, then held at opi.
    task automatic run_until(input logic [OP_W-1:0] opi, input int target, input string tag);
        int g;
        bit left;
        g = 0;
        left = 1'b0;
        do begin
            opcode = (t >= 3) ? opi : 4'($urandom);
            cycle(tag);
            g++;
            if (t != target) left = 1'b1;
        end while (!(left && t == target) && g < 24 && !halted_m);
        chk({tag, "_bound"}, 13'(g < 24), 13'd1);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [OP_W-1:0] opi;
        logic [OP_W-1:0] pool [6];
        pool[0] = OP_LDA; pool[1] = OP_ADD; pool[2] = OP_SUB;
        pool[3] = OP_OUT; pool[4] = OP_HLT; pool[5] = 4'h7;

        clr = 1'b1;
        opcode = OP_LDA;
        model_reset();
        #4;
        chk("reset_outs", dw, '0);
        chk("reset_ts", 13'(tstate), 13'(T1));
        opcode = OP_HLT;
        #2;
        chk("reset_outs_hltop", dw, '0);
        #5 clr = 1'b0;
        opcode = OP_LDA;
        model_reset();

        inc_seen = 0;
        run_until(OP_LDA, 1, "lda1");
        run_until(OP_LDA, 1, "lda2");
        chk("lda_inc_count", 13'(inc_seen), 13'd2);

        run_until(OP_SUB, 1, "sub1");
        run_until(OP_SUB, 1, "sub2");

        run_until(OP_HLT, 4, "hlt_enter");
        repeat (20) cycle("hlt_hold");
        opcode = OP_LDA;
        repeat (3) cycle("hlt_op0");
        chk("hlt_frozen_ts", 13'(tstate), 13'(T4));
        chk("hlt_still_high", 13'(hlt), 13'd1);
        async_clr("hlt_clr");
        chk("hlt_cleared", 13'(hlt), 13'd0);
        run_until(OP_LDA, 1, "after_hlt");

        run_until(OP_ADD, 5, "add_t5");
        async_clr("add_clr");
        run_until(OP_ADD, 1, "add_after");

        run_until(4'h7, 1, "undef7");
        run_until(OP_OUT, 1, "out");

        repeat (150) begin
            opi = ($urandom_range(0, 3) == 0) ? 4'($urandom) : pool[$urandom_range(0, 5)];
            if (opi == OP_HLT) begin
                run_until(opi, 4, "rnd_hlt");
                repeat ($urandom_range(1, 5)) begin
                    opcode = 4'($urandom);
                    cycle("rnd_hlt_hold");
                end
                async_clr("rnd_hlt_clr");
            end else if ($urandom_range(0, 7) == 0) begin
                run_until(opi, $urandom_range(2, 6), "rnd_part");
                async_clr("rnd_midclr");
            end else begin
                run_until(opi, 1, "rnd_instr");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
